// File: rtl/fpu_int_to_float.sv
// ----------------------------------------------------------------------------
// fpu_int_to_float
//   Multi-cycle 32-bit integer to IEEE-754 single converter (FCVT.S.W and
//   FCVT.S.WU). The operand magnitude is left-normalised a few bit positions
//   per cycle. It is then rounded to nearest, ties to even, and the packed
//   result is registered.
//
// Ports
//   CLK      in   1   clock, rising edge
//   RESET_N  in   1   asynchronous active-low reset
//   START    in   1   conversion request, sampled only while idle
//   SIGNED   in   1   1: INT_IN is two's complement, 0: unsigned
//   INT_IN   in   32  integer operand, sampled with START
//   BUSY     out  1   high while normalising or rounding
//   DONE     out  1   one-cycle pulse, RESULT/INEXACT valid from this cycle
//   RESULT   out  32  IEEE-754 single, held until the next DONE
//   INEXACT  out  1   rounding discarded nonzero bits, held with RESULT
//
// Parameter
//   SHIFT_PER_CYCLE  largest normalisation shift taken in one cycle (1,2,4,8)
// ----------------------------------------------------------------------------
module fpu_int_to_float #(
    parameter int SHIFT_PER_CYCLE = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        SIGNED,
    input  logic [31:0] INT_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT,
    output logic        INEXACT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2
    } state_e;

    // Exponent of a magnitude whose leading one sits in bit 31 (127 + 31).
    localparam logic [7:0] EXP_TOP = 8'd158;

    state_e      state_q,   state_d;
    logic [31:0] mag_q,     mag_d;
    logic [7:0]  exp_q,     exp_d;
    logic        sgn_q,     sgn_d;
    logic [31:0] result_q,  result_d;
    logic        inexact_q, inexact_d;
    logic        done_q,    done_d;

    // Rounding datapath. It reads the normalised magnitude, so it is only
    // meaningful while in ROUND.
    logic        guard_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [23:0] rnd_sum;   // {carry, rounded 23-bit fraction}

    always_comb begin
        guard_bit  = mag_q[7];
        sticky_bit = |mag_q[6:0];
        // Round to nearest, ties to even: a tie rounds up only when the kept
        // LSB is odd.
        round_up   = guard_bit & (sticky_bit | mag_q[8]);
        rnd_sum    = {1'b0, mag_q[30:8]} + {23'd0, round_up};
    end

    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        //       path leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        sgn_d     = sgn_q;
        result_d  = result_q;
        inexact_d = inexact_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (INT_IN == 32'd0) begin
                        // Zero has no leading one to find, so it finishes at once as +0.
                        result_d  = 32'd0;
                        inexact_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        sgn_d   = SIGNED & INT_IN[31];
                        // The magnitude of -2^31 wraps back to 0x8000_0000.
                        // Read as unsigned, that value is already correct.
                        mag_d   = sgn_d ? (~INT_IN + 32'd1) : INT_IN;
                        exp_d   = EXP_TOP;
                        state_d = ST_NORM;
                    end
                end
            end

            ST_NORM: begin
                if (mag_q[31 -: SHIFT_PER_CYCLE] == '0) begin
                    // The top S bits are all zero, so a shift by S cannot
                    // overshoot the leading one.
                    mag_d = mag_q << SHIFT_PER_CYCLE;
                    exp_d = exp_q - 8'(SHIFT_PER_CYCLE);
                end else if (!mag_q[31]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'd1;
                end else begin
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                // A fraction carry-out leaves the fraction bits at zero, and
                // the exponent goes up by one.
                result_d  = {sgn_q, exp_q + {7'd0, rnd_sum[23]}, rnd_sum[22:0]};
                inexact_d = guard_bit | sticky_bit;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only. All flops
    //       then see the pre-edge values, and simulation matches hardware.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            mag_q     <= 32'd0;
            exp_q     <= 8'd0;
            sgn_q     <= 1'b0;
            result_q  <= 32'd0;
            inexact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            sgn_q     <= sgn_d;
            result_q  <= result_d;
            inexact_q <= inexact_d;
            done_q    <= done_d;
        end
    end

    assign BUSY    = (state_q != ST_IDLE);
    assign DONE    = done_q;
    assign RESULT  = result_q;
    assign INEXACT = inexact_q;

endmodule

// File: tb/tb_fpu_int_to_float.sv
// ----------------------------------------------------------------------------
// tb_fpu_int_to_float
//   Directed testbench for fpu_int_to_float with SHIFT_PER_CYCLE = 4.
//   Expected values are hand-computed IEEE-754 encodings and cycle latencies.
// ----------------------------------------------------------------------------
module tb_fpu_int_to_float;

    logic        CLK;
    logic        RESET_N;
    logic        START;
    logic        SIGNED;
    logic [31:0] INT_IN;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic        INEXACT;

    int pass_cnt  = 0;
    int check_cnt = 0;

    fpu_int_to_float #(.SHIFT_PER_CYCLE(4)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .SIGNED  (SIGNED),
        .INT_IN  (INT_IN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT),
        .INEXACT (INEXACT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives START for exactly one rising edge (edge k). The task returns #1
    // after edge k with START low. The caller picks the cycle it starts in.
    task automatic issue(input logic sgn, input logic [31:0] val);
        START  = 1'b1;
        SIGNED = sgn;
        INT_IN = val;
        @(posedge CLK);
        #1;
        START  = 1'b0;
    endtask

    // Called #1 after edge k. It counts edges until DONE is seen, giving
    // lat = (DONE edge) - k. busy_ok stays 1 only if BUSY was high in every
    // cycle before DONE.
    task automatic wait_done(output int lat, output bit busy_ok, output bit timed_out);
        lat       = 0;
        busy_ok   = 1'b1;
        timed_out = 1'b0;
        while (!DONE) begin
            if (!BUSY) busy_ok = 1'b0;
            if (lat >= 60) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    // Runs one conversion from a fresh cycle and checks the result, the
    // inexact flag, the latency and BUSY against the expected values.
    task automatic conv(input string name, input logic sgn, input logic [31:0] val,
                        input logic [31:0] exp_res, input logic exp_inx, input int exp_lat);
        int lat;
        bit busy_ok;
        bit to;
        @(negedge CLK);
        issue(sgn, val);
        wait_done(lat, busy_ok, to);
        check_cnt++;
        if (to) $display("FAIL %s timeout: no DONE within 60 cycles", name);
        else if (RESULT !== exp_res)
            $display("FAIL %s result: got %h expected %h", name, RESULT, exp_res);
        else pass_cnt++;
        check_cnt++;
        if (INEXACT !== exp_inx)
            $display("FAIL %s inexact: got %b expected %b", name, INEXACT, exp_inx);
        else pass_cnt++;
        check_cnt++;
        if (lat !== exp_lat || !busy_ok || BUSY !== 1'b0)
            $display("FAIL %s timing: latency %0d expected %0d, busy_ok %0d, busy_at_done %b",
                     name, lat, exp_lat, busy_ok, BUSY);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        START   = 1'b0;
        SIGNED  = 1'b0;
        INT_IN  = 32'd0;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_cnt++;
        if ({BUSY, DONE, RESULT, INEXACT} !== 35'd0)
            $display("FAIL reset_state: got busy %b done %b result %h inexact %b, all expected 0",
                     BUSY, DONE, RESULT, INEXACT);
        else pass_cnt++;
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_basic();
        conv("one",       1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0, 12);
        conv("minus_one", 1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 12);
        conv("int_min",   1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2);
        conv("seven",     1'b0, 32'h0000_0007, 32'h40E0_0000, 1'b0, 10);
    endtask

    task automatic test_rounding();
        conv("umax_carry", 1'b0, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1, 2);
        conv("tie_even",   1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b1, 6);
        conv("tie_odd",    1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b1, 6);
        conv("exact_24b",  1'b0, 32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0, 4);
    endtask

    task automatic test_zero();
        // The inexact flag is left set beforehand, so clearing it is a real check.
        conv("pre_zero",    1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b1, 6);
        conv("zero_signed", 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);
        conv("zero_uns",    1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    endtask

    // A START in the DONE cycle is accepted straight away.
    task automatic test_back_to_back();
        int lat;
        bit busy_ok;
        bit to;
        @(negedge CLK);
        issue(1'b1, 32'h8000_0000);
        wait_done(lat, busy_ok, to);
        check_cnt++;
        if (to || RESULT !== 32'hCF00_0000)
            $display("FAIL b2b_first: got %h expected cf000000 (timeout %0d)", RESULT, to);
        else pass_cnt++;
        issue(1'b0, 32'h0000_0007);
        wait_done(lat, busy_ok, to);
        check_cnt++;
        if (to || RESULT !== 32'h40E0_0000 || lat !== 10 || !busy_ok)
            $display("FAIL b2b_second: got %h lat %0d expected 40e00000 lat 10", RESULT, lat);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        @(negedge CLK);
        issue(1'b1, 32'h0000_0001);
        for (int c = 0; c < 20; c++) begin
            if (c == 2 || c == 5 || c == 8) begin
                START  = 1'b1;
                SIGNED = 1'b0;
                INT_IN = 32'hFFFF_FFFF;
            end else begin
                START  = 1'b0;
            end
            @(posedge CLK);
            #1;
            if (DONE) dones++;
        end
        START = 1'b0;
        check_cnt++;
        if (dones !== 1 || RESULT !== 32'h3F80_0000 || INEXACT !== 1'b0)
            $display("FAIL busy_start: dones %0d result %h, expected 1 done and 3f800000",
                     dones, RESULT);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int dones = 0;
        @(negedge CLK);
        issue(1'b1, 32'h0000_0001);
        repeat (3) @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check_cnt++;
        if ({BUSY, DONE, RESULT, INEXACT} !== 35'd0)
            $display("FAIL mid_reset: got busy %b done %b result %h inexact %b, all expected 0",
                     BUSY, DONE, RESULT, INEXACT);
        else pass_cnt++;
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge CLK);
            #1;
            if (DONE) dones++;
        end
        check_cnt++;
        if (dones !== 0 || BUSY !== 1'b0)
            $display("FAIL mid_reset_nodone: dones %0d busy %b expected 0 and 0", dones, BUSY);
        else pass_cnt++;
        conv("after_reset", 1'b0, 32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0, 4);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_zero();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
